// File: rtl/dds_sweep_ctrl_if.sv
// rtl/dds_sweep_ctrl_if.sv - configuration/command and tuning-word bundle for the DDS sweep sequencer
interface dds_sweep_ctrl_if #(
   parameter int FW = 24,
   parameter int DW = 16
);
   logic          istart;
   logic          istop;
   logic          imode;
   logic [FW-1:0] ifreq_start;
   logic [FW-1:0] ifreq_stop;
   logic [FW-1:0] ifreq_step;
   logic [DW-1:0] idwell;
   logic [FW-1:0] ofreq_word;
   logic          ofreq_load;
   logic          obusy;
   logic          odone;
   logic [1:0]    ostate;

   modport master (
      output istart, istop, imode, ifreq_start, ifreq_stop, ifreq_step, idwell,
      input  ofreq_word, ofreq_load, obusy, odone, ostate
   );

   modport slave (
      input  istart, istop, imode, ifreq_start, ifreq_stop, ifreq_step, idwell,
      output ofreq_word, ofreq_load, obusy, odone, ostate
   );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - steps the DDS tuning word from start to stop, holding each word for a dwell time
module dds_sweep_ctrl #(
   parameter int FW = 24,
   parameter int DW = 16
) (
   input  logic            iclk,
   input  logic            irst,
   dds_sweep_ctrl_if.slave bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_DWELL = 2'd2;
   localparam logic [1:0] S_STEP  = 2'd3;

   logic [1:0]    r_state;
   logic [FW-1:0] r_start;
   logic [FW-1:0] r_stop;
   logic [FW-1:0] r_step;
   logic [DW-1:0] r_dwell;
   logic          r_mode;
   logic [DW-1:0] r_cnt;
   logic [FW-1:0] r_word;
   logic          r_load;
   logic          r_done;
   logic          r_busy;

   logic [1:0]    w_next;
   logic          w_abort;
   logic          w_accept;
   logic          w_end;
   logic [FW:0]   w_sum;
   logic [FW-1:0] w_step_word;
   logic [DW-1:0] w_reload;

   assign w_abort  = bus.istop && (r_state != S_IDLE);
   assign w_accept = (r_state == S_IDLE) && bus.istart && !bus.istop;
   assign w_end    = (r_word >= r_stop);
   assign w_reload = r_dwell - DW'(1);

   // Sum one bit wider so a wrap past full scale clamps to stop instead of restarting low.
   always_comb begin
      w_sum       = {1'b0, r_word} + {1'b0, r_step};
      w_step_word = w_sum[FW-1:0];
      if (w_sum > {1'b0, r_stop}) begin
         w_step_word = r_stop;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = w_accept ? S_LOAD : S_IDLE;
         S_LOAD:  w_next = S_DWELL;
         S_DWELL: w_next = (r_cnt == '0) ? S_STEP : S_DWELL;
         S_STEP:  w_next = (w_end && !r_mode) ? S_IDLE : S_DWELL;
         default: w_next = S_IDLE;
      endcase
      if (w_abort) begin
         w_next = S_IDLE;
      end
   end

   always_ff @(posedge iclk or posedge irst) begin
      if (irst) begin
         r_state <= S_IDLE;
         r_start <= '0;
         r_stop  <= '0;
         r_step  <= '0;
         r_dwell <= '0;
         r_mode  <= 1'b0;
         r_cnt   <= '0;
         r_word  <= '0;
         r_load  <= 1'b0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != S_IDLE);
         r_load  <= 1'b0;
         r_done  <= 1'b0;
         if (!w_abort) begin
            case (r_state)
               S_IDLE: begin
                  if (w_accept) begin
                     r_start <= bus.ifreq_start;
                     r_stop  <= bus.ifreq_stop;
                     r_step  <= (bus.ifreq_step == '0) ? FW'(1) : bus.ifreq_step;
                     r_dwell <= (bus.idwell == '0) ? DW'(1) : bus.idwell;
                     r_mode  <= bus.imode;
                  end
               end
               S_LOAD: begin
                  r_word <= r_start;
                  r_load <= 1'b1;
                  r_cnt  <= w_reload;
               end
               S_DWELL: begin
                  if (r_cnt != '0) begin
                     r_cnt <= r_cnt - DW'(1);
                  end
               end
               S_STEP: begin
                  if (w_end) begin
                     if (r_mode) begin
                        r_word <= r_start;
                        r_load <= 1'b1;
                        r_cnt  <= w_reload;
                     end else begin
                        r_done <= 1'b1;
                     end
                  end else begin
                     r_word <= w_step_word;
                     r_load <= 1'b1;
                     r_cnt  <= w_reload;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.ofreq_word = r_word;
   assign bus.ofreq_load = r_load;
   assign bus.obusy      = r_busy;
   assign bus.odone      = r_done;
   assign bus.ostate     = r_state;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - directed bench for the DDS sweep sequencer
module tb_dds_sweep_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   dds_sweep_ctrl_if #(.FW(24), .DW(16)) u_if ();

   dds_sweep_ctrl #(.FW(24), .DW(16)) u_dut (
      .iclk (clk),
      .irst (rst),
      .bus  (u_if.slave)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [23:0] s, input logic [23:0] p, input logic [23:0] st,
                      input logic [15:0] d, input logic m);
      u_if.ifreq_start = s;
      u_if.ifreq_stop  = p;
      u_if.ifreq_step  = st;
      u_if.idwell      = d;
      u_if.imode       = m;
   endtask

   task automatic kick;
      u_if.istart = 1'b1;
      tick;
      u_if.istart = 1'b0;
   endtask

   task automatic clamp_run(input logic [23:0] stop_v, input logic [23:0] exp2, input string tag);
      logic exp_ld;
      cfg(24'hFFFFF0, stop_v, 24'h000020, 16'd1, 1'b0);
      kick;
      for (int c = 2; c <= 6; c++) begin
         tick;
         exp_ld = (c == 2) || (c == 4);
         check({tag, "_load"}, 32'(u_if.ofreq_load), 32'(exp_ld));
         if (c == 2) check({tag, "_w1"}, 32'(u_if.ofreq_word), 32'hFFFFF0);
         if (c == 4) check({tag, "_w2"}, 32'(u_if.ofreq_word), 32'(exp2));
         check({tag, "_done"}, 32'(u_if.odone), 32'(c == 6));
      end
      check({tag, "_hold"}, 32'(u_if.ofreq_word), 32'(exp2));
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_ld;
      int   seq [5];
      seq = '{5, 6, 7, 5, 6};
      u_if.istart = 1'b0;
      u_if.istop  = 1'b0;
      cfg(24'd0, 24'd0, 24'd0, 16'd0, 1'b0);
      tick;
      tick;
      check("rst_word",  32'(u_if.ofreq_word), 0);
      check("rst_load",  32'(u_if.ofreq_load), 0);
      check("rst_busy",  32'(u_if.obusy), 0);
      check("rst_done",  32'(u_if.odone), 0);
      check("rst_state", 32'(u_if.ostate), 0);
      rst = 1'b0;
      tick;

      // basic single sweep; inputs scrambled after the latch must not matter
      cfg(24'd100, 24'd130, 24'd10, 16'd3, 1'b0);
      kick;
      cfg(24'd7, 24'd9, 24'd1, 16'd5, 1'b1);
      check("basic_c1_state", 32'(u_if.ostate), 1);
      check("basic_c1_busy",  32'(u_if.obusy), 1);
      for (int c = 2; c <= 19; c++) begin
         tick;
         exp_ld = (c <= 14) && ((c - 2) % 4 == 0);
         check("basic_load", 32'(u_if.ofreq_load), 32'(exp_ld));
         if (exp_ld) check("basic_word", 32'(u_if.ofreq_word), 100 + 10 * ((c - 2) / 4));
         check("basic_done", 32'(u_if.odone), 32'(c == 18));
         check("basic_busy", 32'(u_if.obusy), 32'(c < 18));
      end
      check("basic_hold", 32'(u_if.ofreq_word), 130);

      clamp_run(24'hFFFFFF, 24'hFFFFFF, "clamp_full");
      clamp_run(24'hFFFFF8, 24'hFFFFF8, "clamp_stop");

      // continuous with step=0 and dwell=0 fixed up to 1
      cfg(24'd5, 24'd7, 24'd0, 16'd0, 1'b1);
      kick;
      for (int c = 2; c <= 11; c++) begin
         tick;
         exp_ld = (c % 2 == 0);
         check("cont_load", 32'(u_if.ofreq_load), 32'(exp_ld));
         if (exp_ld) check("cont_word", 32'(u_if.ofreq_word), seq[(c - 2) / 2]);
         check("cont_done", 32'(u_if.odone), 0);
         check("cont_busy", 32'(u_if.obusy), 1);
      end
      u_if.istop = 1'b1;
      tick;
      u_if.istop = 1'b0;
      check("cont_stop_busy",  32'(u_if.obusy), 0);
      check("cont_stop_state", 32'(u_if.ostate), 0);
      check("cont_stop_load",  32'(u_if.ofreq_load), 0);
      check("cont_stop_done",  32'(u_if.odone), 0);
      check("cont_stop_word",  32'(u_if.ofreq_word), 6);

      // abort in DWELL of the second word
      cfg(24'd100, 24'd130, 24'd10, 16'd3, 1'b0);
      kick;
      for (int c = 2; c <= 8; c++) tick;
      u_if.istop = 1'b1;
      tick;
      u_if.istop = 1'b0;
      check("abort_busy",  32'(u_if.obusy), 0);
      check("abort_state", 32'(u_if.ostate), 0);
      check("abort_word",  32'(u_if.ofreq_word), 110);
      check("abort_done",  32'(u_if.odone), 0);
      for (int c = 10; c <= 16; c++) begin
         tick;
         check("abort_no_load", 32'(u_if.ofreq_load), 0);
         check("abort_no_done", 32'(u_if.odone), 0);
      end
      check("abort_hold", 32'(u_if.ofreq_word), 110);
      u_if.istart = 1'b1;
      u_if.istop  = 1'b1;
      tick;
      u_if.istart = 1'b0;
      u_if.istop  = 1'b0;
      check("both_state", 32'(u_if.ostate), 0);
      check("both_busy",  32'(u_if.obusy), 0);
      tick;
      check("both_state2", 32'(u_if.ostate), 0);
      check("both_load",   32'(u_if.ofreq_load), 0);

      // start above stop, plus an ignored istart during DWELL
      cfg(24'd50, 24'd20, 24'd5, 16'd2, 1'b0);
      kick;
      for (int c = 2; c <= 8; c++) begin
         tick;
         check("degen_load", 32'(u_if.ofreq_load), 32'(c == 2));
         if (c == 2) check("degen_word", 32'(u_if.ofreq_word), 50);
         check("degen_done", 32'(u_if.odone), 32'(c == 5));
         check("degen_busy", 32'(u_if.obusy), 32'(c < 5));
         u_if.istart = (c == 2);
      end
      check("degen_hold", 32'(u_if.ofreq_word), 50);

      // asynchronous reset mid-DWELL, then a fresh sweep
      cfg(24'd100, 24'd130, 24'd10, 16'd3, 1'b0);
      kick;
      for (int c = 2; c <= 4; c++) tick;
      #2 rst = 1'b1;
      #1;
      check("arst_word",  32'(u_if.ofreq_word), 0);
      check("arst_busy",  32'(u_if.obusy), 0);
      check("arst_state", 32'(u_if.ostate), 0);
      check("arst_load",  32'(u_if.ofreq_load), 0);
      check("arst_done",  32'(u_if.odone), 0);
      tick;
      tick;
      rst = 1'b0;
      tick;
      cfg(24'd200, 24'd220, 24'd20, 16'd1, 1'b0);
      kick;
      for (int c = 2; c <= 6; c++) begin
         tick;
         exp_ld = (c == 2) || (c == 4);
         check("fresh_load", 32'(u_if.ofreq_load), 32'(exp_ld));
         if (c == 2) check("fresh_w1", 32'(u_if.ofreq_word), 200);
         if (c == 4) check("fresh_w2", 32'(u_if.ofreq_word), 220);
         check("fresh_done", 32'(u_if.odone), 32'(c == 6));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS core. It steps the 24-bit phase-accumulator tuning word from a start value to a stop value in fixed increments, holding each word for a programmable dwell time. It runs in single-shot or continuous mode. It sits between the parameter/key configuration logic and the accumulator's frequency-word input, and exports its state for the OLED status page.

## Interface
Parameters:
- FW, 24, tuning-word width.
- DW, 16, dwell-counter width.

Ports:
- iclk, input, 1, system (PLL) clock.
- irst, input, 1, asynchronous active-high reset.
- istart, input, 1, start request, sampled only in IDLE.
- istop, input, 1, abort request. Has priority over istart.
- imode, input, 1. 0 = single sweep, 1 = continuous (restart at start value).
- ifreq_start, input, FW, first tuning word.
- ifreq_stop, input, FW, last tuning word (inclusive).
- ifreq_step, input, FW, increment per step.
- idwell, input, DW, hold cycles per word.
- ofreq_word, output, FW, tuning word to the accumulator.
- ofreq_load, output, 1, one-cycle strobe, high in the first cycle a new ofreq_word value is visible.
- obusy, output, 1, high in LOAD/DWELL/STEP.
- odone, output, 1, one-cycle pulse when a single sweep completes normally.
- ostate, output, 2, current state (0 IDLE, 1 LOAD, 2 DWELL, 3 STEP).

## Operation
- All outputs are registered.
- Reset values: ofreq_word=0, ofreq_load=0, obusy=0, odone=0, ostate=0. Internal shadow registers and the counter also clear to 0.
- IDLE state:
  - istart=1 and istop=0: latch start, stop, step, dwell and mode into shadow registers, then go to LOAD.
  - Inputs may change freely after the latch.
  - Latched step=0 is treated as 1. Latched dwell=0 is treated as 1. Call the effective dwell D.
- LOAD state (1 cycle): ofreq_word←start, ofreq_load←1, cnt←D−1, then go to DWELL.
- DWELL state:
  - cnt==0: go to STEP.
  - Otherwise: cnt←cnt−1.
- STEP state (1 cycle):
  - If word ≥ stop (unsigned), the sweep has ended:
    - Single mode: go to IDLE with odone←1. ofreq_word holds its value.
    - Continuous mode: ofreq_word←start, ofreq_load←1, cnt←D−1, go to DWELL.
  - Otherwise: sum = word + step, computed at FW+1 bits.
    - If the carry is set or sum > stop: ofreq_word←stop.
    - Else: ofreq_word←sum[FW−1:0].
    - In both cases ofreq_load←1, cnt←D−1, go to DWELL.
- istop=1 in any non-IDLE state:
  - Next state is IDLE and obusy falls.
  - odone is not pulsed and no ofreq_load is issued.
  - ofreq_word keeps its current value.
- istart while busy is ignored. istart together with istop in IDLE is ignored.
- start ≥ stop: start is loaded and dwelled once, then the sweep ends (done in single mode, reload of start in continuous mode).
- Reset asserted mid-sweep: immediate return to reset values. No done pulse is issued.

## Timing
- Cycle 0 (IDLE): istart sampled high.
- Cycle 1: LOAD, obusy=1, ostate=1.
- Cycle 2: ofreq_word=start, ofreq_load=1, state DWELL.
- DWELL lasts D cycles, then STEP lasts 1 cycle. The next word is visible D+1 cycles after the previous one.
- Consecutive ofreq_load pulses are exactly D+1 cycles apart, including the continuous-mode wrap.
- odone and obusy=0 appear together, in the cycle after the final STEP.
- A new istart is accepted in that same cycle, since the state is IDLE.
- istop sampled at cycle n gives obusy=0 and ostate=0 at cycle n+1.
- ofreq_load and odone are never high for more than 1 consecutive cycle, except in continuous mode with D=1 where loads fall every 2 cycles.

## Test plan
- Basic single sweep: start=100, stop=130, step=10, dwell=3, imode=0, istart at cycle 0 → ofreq_load at cycles 2, 6, 10, 14 with words 100, 110, 120, 130; odone=1 and obusy=0 at cycle 18; word stays 130.
- Clamp/overflow: start=0xFFFFF0, stop=0xFFFFFF, step=0x20, dwell=1 → words 0xFFFFF0 then 0xFFFFFF (carry clamp), then done; no wrap to a small value. Repeat with stop=0xFFFFF8 → second word is 0xFFFFF8.
- Continuous with zero-fixups: start=5, stop=7, step=0, dwell=0, imode=1 → words 5, 6, 7, 5, 6, … with loads every 2 cycles; odone never asserted.
- Abort: the basic-sweep configuration with istop at cycle 8 → obusy=0 and ostate=0 at cycle 9; ofreq_word=110; no odone; the later 120 load never occurs. istart and istop together in IDLE → nothing happens.
- Degenerate: start=50, stop=20, step=5, dwell=2, single → one load of 50 at cycle 2, odone at cycle 5. istart pulsed during DWELL → ignored, no restart.
- Reset: assert irst in the middle of DWELL → all outputs 0 asynchronously. After release, a fresh istart sweeps correctly from the new inputs.
